// File: rtl/sdp_wdma_pkg.sv
// Shared definitions for the SDP write-DMA command path: field widths,
// payload layouts and bit offsets, precision encodings, FSM state enum.
package sdp_wdma_pkg;

    localparam int unsigned AW  = 59;   // 32-byte-aligned address width
    localparam int unsigned SW  = 13;   // line size (atoms minus 1)
    localparam int unsigned STW = 27;   // stride width, 32B units
    localparam int unsigned CW  = 13;   // channel field width
    localparam int unsigned SNW = 9;    // surface counter width

    localparam int unsigned SPT_PD_W = 15;
    localparam int unsigned DMA_PD_W = 74;

    // spt payload: {last, odd, size}
    localparam int unsigned SPT_SIZE_LSB = 0;
    localparam int unsigned SPT_ODD      = 13;
    localparam int unsigned SPT_LAST     = 14;

    // dma payload: {last, odd, size, addr}
    localparam int unsigned DMA_ADDR_LSB = 0;
    localparam int unsigned DMA_SIZE_LSB = 59;
    localparam int unsigned DMA_ODD      = 72;
    localparam int unsigned DMA_LAST     = 73;

    typedef enum logic [1:0] {
        PREC_INT8  = 2'd0,
        PREC_INT16 = 2'd1,
        PREC_FP16  = 2'd2
    } prec_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic          last;
        logic          odd;
        logic [SW-1:0] size;
    } spt_pd_t;

    typedef struct packed {
        logic          last;
        logic          odd;
        logic [SW-1:0] size;
        logic [AW-1:0] addr;
    } dma_pd_t;

    // Surfaces minus 1: a surface holds 32 int8 or 16 int16/fp16 channels
    function automatic logic [SNW-1:0] surf_num_f(input logic [CW-1:0] channel,
                                                  input logic [1:0]    precision);
        if (precision == PREC_INT8)
            return SNW'(channel >> 5);
        else
            return SNW'(channel >> 4);
    endfunction

endpackage

// File: rtl/sdp_wdma_cmd_oreg.sv
// Single-entry valid/data output register with its own handshake.
// Ports: clk/rst_n; load + load_pd capture a new entry and set pvld;
//        prdy retires the entry; pvld/pd are registered outputs.
// A load takes priority over retirement in the same cycle.
module sdp_wdma_cmd_oreg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_pd,
    input  logic         prdy,
    output logic         pvld,
    output logic [W-1:0] pd
);

    // Valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pvld <= 1'b0;
        end else if (load) begin
            pvld <= 1'b1;
        end else if (prdy) begin
            pvld <= 1'b0;
        end
    end

    // Payload holds while waiting for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd <= '0;
        end else if (load) begin
            pd <= load_pd;
        end
    end

endmodule

// File: rtl/sdp_wdma_cmd_gen.sv
// SDP write-DMA command generator. On op_load walks surfaces x lines of the
// output cube and issues one command per line on the spt and dma channels.
// Ports: nvdla_core_clk/nvdla_core_rstn; op_load start pulse; reg2dp_* layer
//        configuration (sampled on op_load); cmd2dat_spt_* and cmd2dat_dma_*
//        ready/valid command channels; cmd_busy while a layer is in flight.
module sdp_wdma_cmd_gen
    import sdp_wdma_pkg::*;
(
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                op_load,
    input  logic [31:0]         reg2dp_dst_base_addr_high,
    input  logic [26:0]         reg2dp_dst_base_addr_low,
    input  logic [STW-1:0]      reg2dp_dst_line_stride,
    input  logic [STW-1:0]      reg2dp_dst_surface_stride,
    input  logic [SW-1:0]       reg2dp_width,
    input  logic [SW-1:0]       reg2dp_height,
    input  logic [CW-1:0]       reg2dp_channel,
    input  logic [1:0]          reg2dp_proc_precision,
    output logic                cmd2dat_spt_pvld,
    input  logic                cmd2dat_spt_prdy,
    output logic [SPT_PD_W-1:0] cmd2dat_spt_pd,
    output logic                cmd2dat_dma_pvld,
    input  logic                cmd2dat_dma_prdy,
    output logic [DMA_PD_W-1:0] cmd2dat_dma_pd,
    output logic                cmd_busy
);

    state_e           state;
    state_e           state_nxt;

    logic [AW-1:0]    line_addr;
    logic [AW-1:0]    surf_addr;
    logic [AW-1:0]    line_addr_inc_c;
    logic [AW-1:0]    surf_addr_inc_c;
    logic [SW-1:0]    width_q;
    logic [SW-1:0]    height_q;
    logic [SW-1:0]    line_cnt;
    logic [SNW-1:0]   surf_num_q;
    logic [SNW-1:0]   surf_cnt;
    logic [STW-1:0]   line_stride_q;
    logic [STW-1:0]   surf_stride_q;

    logic             load_c;
    logic             issue_c;
    logic             last_c;
    logic             spt_hold_c;
    logic             dma_hold_c;
    spt_pd_t          spt_new_c;
    dma_pd_t          dma_new_c;

    // Issue only when both output slots are free or retiring this cycle
    assign load_c  = (state == ST_IDLE) && op_load;
    assign issue_c = (state == ST_RUN)
                   && (!cmd2dat_spt_pvld || cmd2dat_spt_prdy)
                   && (!cmd2dat_dma_pvld || cmd2dat_dma_prdy);
    assign last_c  = (line_cnt == height_q) && (surf_cnt == surf_num_q);

    // Entries that will still be pending after this edge (no issue in DRAIN)
    assign spt_hold_c = cmd2dat_spt_pvld && !cmd2dat_spt_prdy;
    assign dma_hold_c = cmd2dat_dma_pvld && !cmd2dat_dma_prdy;

    assign line_addr_inc_c = line_addr + AW'(line_stride_q);
    assign surf_addr_inc_c = surf_addr + AW'(surf_stride_q);

    // Command payloads; odd flags an odd atom count (width is atoms minus 1)
    always_comb begin
        spt_new_c      = '0;
        dma_new_c      = '0;
        spt_new_c.last = last_c;
        spt_new_c.odd  = ~width_q[0];
        spt_new_c.size = width_q;
        dma_new_c.last = last_c;
        dma_new_c.odd  = ~width_q[0];
        dma_new_c.size = width_q;
        dma_new_c.addr = line_addr;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (op_load) state_nxt = ST_RUN;
            ST_RUN:   if (issue_c && last_c) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!spt_hold_c && !dma_hold_c) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and busy flag
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= ST_IDLE;
            cmd_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_busy <= (state_nxt != ST_IDLE);
        end
    end

    // Layer configuration, latched at start
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            width_q       <= '0;
            height_q      <= '0;
            surf_num_q    <= '0;
            line_stride_q <= '0;
            surf_stride_q <= '0;
        end else if (load_c) begin
            width_q       <= reg2dp_width;
            height_q      <= reg2dp_height;
            surf_num_q    <= surf_num_f(reg2dp_channel, reg2dp_proc_precision);
            line_stride_q <= reg2dp_dst_line_stride;
            surf_stride_q <= reg2dp_dst_surface_stride;
        end
    end

    // Cube walk: lines within a surface, then next surface
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            line_cnt  <= '0;
            surf_cnt  <= '0;
            line_addr <= '0;
            surf_addr <= '0;
        end else if (load_c) begin
            line_cnt  <= '0;
            surf_cnt  <= '0;
            line_addr <= {reg2dp_dst_base_addr_high, reg2dp_dst_base_addr_low};
            surf_addr <= {reg2dp_dst_base_addr_high, reg2dp_dst_base_addr_low};
        end else if (issue_c) begin
            if (line_cnt < height_q) begin
                line_cnt  <= line_cnt + SW'(1);
                line_addr <= line_addr_inc_c;
            end else begin
                line_cnt  <= '0;
                surf_cnt  <= surf_cnt + SNW'(1);
                surf_addr <= surf_addr_inc_c;
                line_addr <= surf_addr_inc_c;
            end
        end
    end

    sdp_wdma_cmd_oreg #(.W(SPT_PD_W)) u_spt_oreg (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .load    (issue_c),
        .load_pd (spt_new_c),
        .prdy    (cmd2dat_spt_prdy),
        .pvld    (cmd2dat_spt_pvld),
        .pd      (cmd2dat_spt_pd)
    );

    sdp_wdma_cmd_oreg #(.W(DMA_PD_W)) u_dma_oreg (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .load    (issue_c),
        .load_pd (dma_new_c),
        .prdy    (cmd2dat_dma_prdy),
        .pvld    (cmd2dat_dma_pvld),
        .pd      (cmd2dat_dma_pd)
    );

endmodule

// File: tb/tb_sdp_wdma_cmd_gen.sv
// Bench for sdp_wdma_cmd_gen: directed scenarios plus random layers, checked
// against a cube-walk model that lists every expected command per layer.
module tb_sdp_wdma_cmd_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        op_load = 1'b0;
    logic [31:0] base_hi = '0;
    logic [26:0] base_lo = '0;
    logic [26:0] line_stride = '0;
    logic [26:0] surf_stride = '0;
    logic [12:0] width = '0;
    logic [12:0] height = '0;
    logic [12:0] channel = '0;
    logic [1:0]  precision = '0;
    logic        spt_pvld;
    logic        spt_prdy = 1'b0;
    logic [14:0] spt_pd;
    logic        dma_pvld;
    logic        dma_prdy = 1'b0;
    logic [73:0] dma_pd;
    logic        cmd_busy;

    int errors = 0;
    int checks = 0;

    logic [14:0] spt_q[$];
    logic [73:0] dma_q[$];
    int          spt_acc;
    int          dma_acc;
    logic [58:0] first_dma_addr;
    logic [58:0] last_dma_addr;

    always #5 clk = ~clk;

    sdp_wdma_cmd_gen dut (
        .nvdla_core_clk            (clk),
        .nvdla_core_rstn           (rstn),
        .op_load                   (op_load),
        .reg2dp_dst_base_addr_high (base_hi),
        .reg2dp_dst_base_addr_low  (base_lo),
        .reg2dp_dst_line_stride    (line_stride),
        .reg2dp_dst_surface_stride (surf_stride),
        .reg2dp_width              (width),
        .reg2dp_height             (height),
        .reg2dp_channel            (channel),
        .reg2dp_proc_precision     (precision),
        .cmd2dat_spt_pvld          (spt_pvld),
        .cmd2dat_spt_prdy          (spt_prdy),
        .cmd2dat_spt_pd            (spt_pd),
        .cmd2dat_dma_pvld          (dma_pvld),
        .cmd2dat_dma_prdy          (dma_prdy),
        .cmd2dat_dma_pd            (dma_pd),
        .cmd_busy                  (cmd_busy)
    );

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load a layer and build the full expected command list from the cube shape
    task automatic start_layer(input logic [31:0] hi, input logic [26:0] lo,
                               input logic [26:0] ls, input logic [26:0] ss,
                               input logic [12:0] w, input logic [12:0] h,
                               input logic [12:0] ch, input logic [1:0] pr);
        int          n_surf;
        logic [58:0] base;
        logic [58:0] addr;
        logic        lst;
        logic        odd;
        @(negedge clk);
        base_hi = hi; base_lo = lo; line_stride = ls; surf_stride = ss;
        width = w; height = h; channel = ch; precision = pr;
        op_load = 1'b1;
        n_surf = (pr == 2'd0) ? (int'(ch) / 32) + 1 : (int'(ch) / 16) + 1;
        base = {hi, lo};
        odd  = ((int'(w) + 1) % 2) == 1;
        spt_q.delete();
        dma_q.delete();
        for (int s = 0; s < n_surf; s++) begin
            for (int l = 0; l <= int'(h); l++) begin
                addr = base + 59'(s) * 59'(ss) + 59'(l) * 59'(ls);
                lst  = (s == n_surf - 1) && (l == int'(h));
                spt_q.push_back({lst, odd, w});
                dma_q.push_back({lst, odd, w, addr});
            end
        end
        spt_acc = 0;
        dma_acc = 0;
        cycle(1'b1, 1'b1, 1'b0);
        chk("busy_start", 74'(cmd_busy), 74'(1));
    endtask

    // One clock: drive readies, scramble config, score handshakes due at the next edge
    task automatic cycle(input logic rs, input logic rd, input logic ld);
        logic [14:0] es;
        logic [73:0] ed;
        int          diff;
        @(negedge clk);
        op_load     = ld;
        spt_prdy    = rs;
        dma_prdy    = rd;
        base_hi     = $urandom;
        base_lo     = 27'($urandom);
        line_stride = 27'($urandom);
        surf_stride = 27'($urandom);
        width       = 13'($urandom);
        height      = 13'($urandom);
        channel     = 13'($urandom);
        precision   = 2'($urandom);
        if (spt_pvld) begin
            if (spt_q.size() == 0) chk("spt_extra", 74'(1), 74'(0));
            else if (rs) begin
                es = spt_q.pop_front();
                chk("spt_pd", 74'(spt_pd), 74'(es));
                spt_acc++;
            end
        end
        if (dma_pvld) begin
            if (dma_q.size() == 0) chk("dma_extra", 74'(1), 74'(0));
            else if (rd) begin
                ed = dma_q.pop_front();
                chk("dma_pd", dma_pd, ed);
                if (dma_acc == 0) first_dma_addr = dma_pd[58:0];
                last_dma_addr = dma_pd[58:0];
                dma_acc++;
            end
        end
        diff = spt_acc - dma_acc;
        chk("chan_skew", 74'((diff > 1) || (diff < -1)), 74'(0));
    endtask

    // Run until all expected commands are taken, then expect idle
    task automatic finish_layer(input int pct);
        int n = 0;
        while ((spt_q.size() != 0 || dma_q.size() != 0) && n < 3000) begin
            cycle(32'($urandom_range(0, 99)) < 32'(pct),
                  32'($urandom_range(0, 99)) < 32'(pct), 1'b0);
            n++;
        end
        chk("layer_timeout", 74'(n >= 3000), 74'(0));
        cycle(1'b1, 1'b1, 1'b0);
        chk("idle_busy", 74'(cmd_busy), 74'(0));
        chk("idle_spt_vld", 74'(spt_pvld), 74'(0));
        chk("idle_dma_vld", 74'(dma_pvld), 74'(0));
    endtask

    initial begin
        logic [14:0] held;
        int          n;
        logic [1:0]  pr;
        logic [12:0] ch;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_spt_vld", 74'(spt_pvld), 74'(0));
        chk("rst_dma_vld", 74'(dma_pvld), 74'(0));
        chk("rst_spt_pd", 74'(spt_pd), 74'(0));
        chk("rst_dma_pd", dma_pd, 74'(0));
        chk("rst_busy", 74'(cmd_busy), 74'(0));
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic walk, back-to-back commands
        start_layer(32'h0, 27'h100, 27'h10, 27'h0, 13'd3, 13'd1, 13'd31, 2'd0);
        n = 0;
        while (!spt_pvld && n < 10) begin cycle(1'b1, 1'b1, 1'b0); n++; end
        chk("basic_first_timeout", 74'(n >= 10), 74'(0));
        chk("basic_dma0", dma_pd, {1'b0, 1'b0, 13'd3, 59'h100});
        chk("basic_spt0", 74'(spt_pd), 74'(15'h0003));
        cycle(1'b1, 1'b1, 1'b0);
        chk("basic_dma1_vld", 74'(dma_pvld), 74'(1));
        chk("basic_dma1", dma_pd, {1'b1, 1'b0, 13'd3, 59'h110});
        chk("basic_spt1", 74'(spt_pd), 74'(15'h4003));
        cycle(1'b1, 1'b1, 1'b0);
        chk("basic_busy_drop", 74'(cmd_busy), 74'(0));
        chk("basic_vld_drop", 74'(dma_pvld | spt_pvld), 74'(0));

        // Two surfaces, int16
        start_layer(32'h0, 27'h200, 27'h8, 27'h40, 13'd2, 13'd0, 13'd31, 2'd1);
        finish_layer(100);
        chk("ms_count", 74'(dma_acc), 74'(2));
        chk("ms_first_addr", 74'(first_dma_addr), 74'(59'h200));
        chk("ms_last_addr", 74'(last_dma_addr), 74'(59'h240));

        // spt stalled while dma keeps accepting
        start_layer(32'h1, 27'h40, 27'h3, 27'h100, 13'd5, 13'd3, 13'd0, 2'd0);
        n = 0;
        while (!spt_pvld && n < 10) begin cycle(1'b0, 1'b0, 1'b0); n++; end
        chk("skew_first_timeout", 74'(n >= 10), 74'(0));
        held = spt_pd;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("skew_spt_stable", 74'(spt_pd), 74'(held));
            chk("skew_spt_vld", 74'(spt_pvld), 74'(1));
            if (k > 0) chk("skew_no_reissue", 74'(dma_pvld), 74'(0));
        end
        chk("skew_dma_taken", 74'(dma_acc), 74'(1));
        finish_layer(100);

        // Address wraps modulo 2^59
        start_layer(32'hFFFF_FFFF, 27'h7FF_FFFF, 27'h2, 27'h0, 13'd7, 13'd1, 13'd0, 2'd0);
        finish_layer(100);
        chk("wrap_first", 74'(first_dma_addr), 74'({59{1'b1}}));
        chk("wrap_addr", 74'(last_dma_addr), 74'(59'd1));

        // op_load while busy is ignored
        start_layer(32'h0, 27'h1000, 27'h20, 27'h400, 13'd9, 13'd2, 13'd63, 2'd0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        finish_layer(80);
        chk("reload_count", 74'(dma_acc), 74'(6));

        // Reset mid-layer, then restart from the base
        start_layer(32'h0, 27'h1234, 27'h11, 27'h0, 13'd4, 13'd3, 13'd0, 2'd0);
        n = 0;
        while (!dma_pvld && n < 10) begin cycle(1'b0, 1'b0, 1'b0); n++; end
        chk("abort_wait_timeout", 74'(n >= 10), 74'(0));
        #2 rstn = 1'b0;
        #1;
        chk("abort_spt_vld", 74'(spt_pvld), 74'(0));
        chk("abort_dma_vld", 74'(dma_pvld), 74'(0));
        chk("abort_dma_pd", dma_pd, 74'(0));
        chk("abort_spt_pd", 74'(spt_pd), 74'(0));
        chk("abort_busy", 74'(cmd_busy), 74'(0));
        spt_q.delete();
        dma_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        start_layer(32'h0, 27'h1234, 27'h11, 27'h0, 13'd4, 13'd3, 13'd0, 2'd0);
        finish_layer(100);
        chk("restart_addr", 74'(first_dma_addr), 74'(59'h1234));
        chk("restart_count", 74'(dma_acc), 74'(4));

        // Random layers under random backpressure
        for (int r = 0; r < 8; r++) begin
            pr = 2'($urandom_range(0, 2));
            ch = (pr == 2'd0) ? 13'($urandom_range(0, 127)) : 13'($urandom_range(0, 63));
            start_layer($urandom, 27'($urandom), 27'($urandom), 27'($urandom),
                        13'($urandom), 13'($urandom_range(0, 5)), ch, pr);
            finish_layer(60);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
